// File: rtl/counter_b4_sequencer.sv
// Purpose  : command sequencer that plays buffered {mode, data, length} commands
//            onto the enable/mode/D inputs of the 4-bit up/down/load counter.
// Latency  : a command accepted at edge k into an empty FIFO enables the counter after edge k+1.
// Backpressure: cmd_ready = !full, from the FIFO count only; a same-cycle pop does not free a slot.
//
// Ports (top counter_b4_sequencer):
//   b4_clk, b4_reset_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_mode, cmd_data, cmd_len payload
//   b4_rco                          ripple-carry from the counter (abort source when enabled)
//   b4_enable, b4_mode, b4_D        registered counter controls
//   busy, done, cmd_abort           status: running, last cycle of a command, early end on rco
//   fifo_count                      commands currently buffered
//
// Optional feature: define SEQ_RCO_ABORT_EN to end a non-load command early when b4_rco is seen.
// Without it b4_rco is ignored and cmd_abort is tied 0.

// Generic synchronous FIFO with occupancy count.
// Latency: data written at an edge is visible on rdat_o after that edge.
// Backpressure: pushes while full and pops while empty are ignored.
module seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdat_i,
    output logic [W-1:0]               rdat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointers wrap naturally; the extra count bit
    // separates full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end
endmodule

// Command sequencer top.
// Latency: accept at edge k -> b4_enable high after edge k+1; back-to-back commands run with no gap.
// Backpressure: cmd_ready drops only when the FIFO holds DEPTH commands.
module counter_b4_sequencer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                   b4_clk,
    input  logic                   b4_reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_mode,
    input  logic [3:0]             cmd_data,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   b4_rco,
    output logic                   b4_enable,
    output logic [1:0]             b4_mode,
    output logic [3:0]             b4_D,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_abort,
    output logic [$clog2(DEPTH):0] fifo_count
);
    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0]       data;
        logic [LEN_W-1:0] len;
    } cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       data_q, data_d;
    logic             en_q, en_d;

    cmd_t             push_cmd;
    cmd_t             head_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             rco_hit;
    logic             end_cmd;
    logic             done_c;
    logic             abort_c;

    assign push_cmd = '{mode: cmd_mode, data: cmd_data, len: cmd_len};
    assign cmd_ready = !fifo_full;

    seq_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (b4_clk),
        .rst_n   (b4_reset_n),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdat_i  (push_cmd),
        .rdat_o  (head_cmd),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SEQ_RCO_ABORT_EN
    // Load mode legitimately parks the counter at any value, so rco only
    // terminates counting modes.
    assign rco_hit = b4_rco && (mode_q != 2'b11);
`else
    logic unused_rco;
    assign unused_rco = b4_rco;
    assign rco_hit    = 1'b0;
`endif

    assign end_cmd = (rem_q == '0) || rco_hit;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        data_d  = data_q;
        pop     = 1'b0;
        done_c  = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // mode/D keep their last values while idle; only enable drops.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    mode_d  = head_cmd.mode;
                    data_d  = head_cmd.data;
                    rem_d   = head_cmd.len;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_cmd) begin
                    done_c  = 1'b1;
                    // An rco on the natural last cycle is an ordinary completion.
                    abort_c = rco_hit && (rem_q != '0);
                    if (!fifo_empty) begin
                        // Chain straight into the next command so the counter
                        // keeps its value.
                        pop    = 1'b1;
                        mode_d = head_cmd.mode;
                        data_d = head_cmd.data;
                        rem_d  = head_cmd.len;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        en_d = (state_d == ST_RUN);
    end

    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= 2'b00;
            data_q  <= 4'h0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign b4_enable = en_q;
    assign b4_mode   = mode_q;
    assign b4_D      = data_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_c;
    assign cmd_abort = abort_c;
endmodule

// File: tb/tb_counter_b4_sequencer.sv
// Bench for counter_b4_sequencer: cycle table for single, back-to-back and gapped
// commands, plus hand sequences for FIFO full, rco abort and mid-run reset.
// A small up/down/load counter model closes the loop on b4_enable/b4_mode/b4_D and drives b4_rco.
module tb_counter_b4_sequencer;
    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic       b4_rco;
    logic       b4_enable;
    logic [1:0] b4_mode;
    logic [3:0] b4_D;
    logic       busy;
    logic       done;
    logic       cmd_abort;
    logic [2:0] fifo_count;
    logic [3:0] q;

    int n_checks = 0;
    int n_fail   = 0;

    counter_b4_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
        .b4_clk     (clk),
        .b4_reset_n (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .b4_rco     (b4_rco),
        .b4_enable  (b4_enable),
        .b4_mode    (b4_mode),
        .b4_D       (b4_D),
        .busy       (busy),
        .done       (done),
        .cmd_abort  (cmd_abort),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: 00 up, 01 down, 10 hold, 11 load; disabled clears Q.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'h0;
        end else if (!b4_enable) begin
            q <= 4'h0;
        end else begin
            case (b4_mode)
                2'b00: q <= q + 4'h1;
                2'b01: q <= q - 4'h1;
                2'b10: q <= q;
                default: q <= b4_D;
            endcase
        end
    end
    assign b4_rco = b4_enable && (b4_mode == 2'b00) && (q == 4'hF);

    typedef struct {
        logic       vld;
        logic [1:0] md;
        logic [3:0] dat;
        logic [3:0] len;
        logic       en;
        logic [1:0] mo;
        logic [3:0] d;
        logic       bsy;
        logic       dn;
        logic       rdy;
        logic [2:0] cnt;
        logic [3:0] qv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic [1:0] md, input logic [3:0] dat,
                       input logic [3:0] len, input logic en, input logic [1:0] mo,
                       input logic [3:0] d, input logic bsy, input logic dn,
                       input logic rdy, input logic [2:0] cnt, input logic [3:0] qv);
        vec_t v;
        v = '{vld, md, dat, len, en, mo, d, bsy, dn, rdy, cnt, qv};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] d, input logic [3:0] l);
        cmd_valid = v;
        cmd_mode  = m;
        cmd_data  = d;
        cmd_len   = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int n_done;
        int n_abort;
        int n_both;
        logic [3:0] last_d;

        rst_n = 1'b0;
        drive(1'b0, 2'b00, 4'h0, 4'h0);

        // Cycle table; each row is driven, clocked once, then outputs are sampled.
        //   vld md     dat   len   en  mo     d     bsy dn  rdy cnt  q
        // single {10,0,len=3}
        add(1, 2'b10, 4'h0, 4'd3, 0, 2'b00, 4'h0, 0, 0, 1, 3'd1, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b10, 4'h0, 1, 0, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b10, 4'h0, 1, 0, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b10, 4'h0, 1, 0, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b10, 4'h0, 1, 1, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b10, 4'h0, 0, 0, 1, 3'd0, 4'h0);
        // back-to-back load 5 then count up x3: Q 5,6,7,8
        add(1, 2'b11, 4'h5, 4'd0, 0, 2'b10, 4'h0, 0, 0, 1, 3'd1, 4'h0);
        add(1, 2'b00, 4'h0, 4'd2, 1, 2'b11, 4'h5, 1, 1, 1, 3'd1, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h0, 1, 0, 1, 3'd0, 4'h5);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h0, 1, 0, 1, 3'd0, 4'h6);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h0, 1, 1, 1, 3'd0, 4'h7);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'h0, 0, 0, 1, 3'd0, 4'h8);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'h0, 0, 0, 1, 3'd0, 4'h0);
        // gap: count-up command, idle, count-up again restarts from 0
        add(1, 2'b00, 4'h3, 4'd1, 0, 2'b00, 4'h0, 0, 0, 1, 3'd1, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h3, 1, 0, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h3, 1, 1, 1, 3'd0, 4'h1);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'h3, 0, 0, 1, 3'd0, 4'h2);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'h3, 0, 0, 1, 3'd0, 4'h0);
        add(1, 2'b00, 4'h0, 4'd1, 0, 2'b00, 4'h3, 0, 0, 1, 3'd1, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h0, 1, 0, 1, 3'd0, 4'h0);
        add(0, 2'b00, 4'h0, 4'd0, 1, 2'b00, 4'h0, 1, 1, 1, 3'd0, 4'h1);
        add(0, 2'b00, 4'h0, 4'd0, 0, 2'b00, 4'h0, 0, 0, 1, 3'd0, 4'h2);

        // Reset state
        #2;
        check("rst_outputs", {28'h0, b4_enable, busy, done, cmd_abort}, 32'h0);
        check("rst_mode_d", {26'h0, b4_mode, b4_D}, 32'h0);
        check("rst_count_ready", {28'h0, fifo_count, cmd_ready}, 32'h1);
        step();
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].md, vecs[i].dat, vecs[i].len);
            step();
            check($sformatf("vec%0d", i),
                  {15'h0, b4_enable, b4_mode, b4_D, busy, done, cmd_ready, fifo_count, q},
                  {15'h0, vecs[i].en, vecs[i].mo, vecs[i].d, vecs[i].bsy, vecs[i].dn,
                   vecs[i].rdy, vecs[i].cnt, vecs[i].qv});
            check($sformatf("vec%0d_abort", i), {31'h0, cmd_abort}, 32'h0);
        end

        // FIFO fill: long hold command runs while four short ones queue up.
        drive(1'b1, 2'b10, 4'h0, 4'd15);
        step();
        drive(1'b0, 2'b00, 4'h0, 4'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 4'(i), 4'd0);
            step();
        end
        check("full_count", {29'h0, fifo_count}, 32'd4);
        check("full_ready", {31'h0, cmd_ready}, 32'd0);
        drive(1'b1, 2'b00, 4'hE, 4'd0);
        n = 0;
        while (!cmd_ready && n < 40) begin
            step();
            n++;
        end
        check("full_wait_cycles", n, 32'd12);
        check("first_pop_count", {29'h0, fifo_count}, 32'd3);
        step();
        check("held_push_count", {29'h0, fifo_count}, 32'd3);
        check("held_push_head", {26'h0, b4_mode, b4_D}, {26'h0, 2'b00, 4'h1});
        drive(1'b0, 2'b00, 4'h0, 4'd0);
        n = 0;
        n_done = 0;
        last_d = 4'h0;
        while (busy && n < 40) begin
            if (done) begin
                n_done++;
                last_d = b4_D;
            end
            step();
            n++;
        end
        check("drain_done_pulses", n_done, 32'd4);
        check("drain_last_data", {28'h0, last_d}, 32'hE);
        check("drain_count", {29'h0, fifo_count}, 32'd0);

        // rco: load 14, then count up for 16 cycles.
        drive(1'b1, 2'b11, 4'hE, 4'd0);
        step();
        drive(1'b1, 2'b00, 4'h0, 4'd15);
        step();
        drive(1'b0, 2'b00, 4'h0, 4'd0);
        step();
        check("rco_start", {25'h0, busy, b4_mode, q}, {25'h0, 1'b1, 2'b00, 4'hE});
        n = 0;
        n_done = 0;
        n_abort = 0;
        n_both = 0;
        while (busy && n < 40) begin
            if (done) n_done++;
            if (cmd_abort) n_abort++;
            if (done && cmd_abort) n_both++;
            step();
            n++;
        end
`ifdef SEQ_RCO_ABORT_EN
        check("rco_run_cycles", n, 32'd2);
        check("rco_abort_pulses", n_abort, 32'd1);
        check("rco_done_with_abort", n_both, 32'd1);
`else
        check("rco_run_cycles", n, 32'd16);
        check("rco_abort_pulses", n_abort, 32'd0);
        check("rco_done_with_abort", n_both, 32'd0);
`endif
        check("rco_done_pulses", n_done, 32'd1);
        check("rco_idle_enable", {31'h0, b4_enable}, 32'd0);

        // Reset asserted mid-run with a command still queued.
        drive(1'b1, 2'b00, 4'h0, 4'd7);
        step();
        drive(1'b1, 2'b01, 4'h0, 4'd2);
        step();
        drive(1'b0, 2'b00, 4'h0, 4'd0);
        step();
        check("pre_rst_state", {29'h0, b4_enable, busy, 1'b0}, {29'h0, 1'b1, 1'b1, 1'b0});
        check("pre_rst_count", {29'h0, fifo_count}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_enable", {31'h0, b4_enable}, 32'd0);
        check("rst_mid_count_ready", {28'h0, fifo_count, cmd_ready}, 32'h1);
        check("rst_mid_status", {29'h0, busy, done, cmd_abort}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", {28'h0, b4_enable, busy, fifo_count[1:0]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
